// File: rtl/data_sampler_mv.sv
// data_sampler_mv: oversampled serial-bit sampler with 3- or 5-sample
// majority vote around the bit centre. RX_IN is synchronised first; the
// window position and vote size are latched when a window opens so that
// configuration changes only affect the next window.
module data_sampler_mv #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      data_sample_en,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      vote_mode,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic                      noise_err,
  output logic                      cfg_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_t;

  localparam logic [PRESCALE_WIDTH-1:0] MIN_PS3 = PRESCALE_WIDTH'(4);
  localparam logic [PRESCALE_WIDTH-1:0] MIN_PS5 = PRESCALE_WIDTH'(8);

  logic                      rx_s;
  state_t                    state, state_next;
  logic [4:0]                slots;
  logic [4:0]                valid;
  logic [PRESCALE_WIDTH-1:0] first_reg;
  logic                      five_reg;

  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] first_idx;
  logic [PRESCALE_WIDTH-1:0] offset;
  logic [PRESCALE_WIDTH-1:0] last_off;
  logic                      in_win;
  logic                      is_last;
  logic [4:0]                valid_after;
  logic [4:0]                need_mask;
  logic                      start;
  logic                      capture;
  logic [4:0]                used;
  logic [2:0]                ones;
  logic                      vote_bit;
  logic                      vote_noise;
  logic                      vote_now;

  // Input synchroniser; a zero-stage build uses the raw line directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      // Shift chain, reset to the idle-high line level.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync <= '1;
        else     sync <= SYNC_STAGES'({sync, RX_IN});
      end
      assign rx_s = sync[SYNC_STAGES-1];
    end
  endgenerate

  // Window geometry from the live inputs (used only when a window opens)
  // and from the latched values (used while collecting).
  assign half      = prescale >> 1;
  assign first_idx = half - (vote_mode ? PRESCALE_WIDTH'(2) : PRESCALE_WIDTH'(1));
  assign cfg_err   = vote_mode ? (prescale < MIN_PS5) : (prescale < MIN_PS3);

  assign offset      = edge_cnt - first_reg;
  assign last_off    = five_reg ? PRESCALE_WIDTH'(4) : PRESCALE_WIDTH'(2);
  assign in_win      = (edge_cnt >= first_reg) && (offset <= last_off);
  assign is_last     = (offset == last_off);
  assign valid_after = valid | (5'b00001 << offset[2:0]);
  assign need_mask   = five_reg ? 5'b11111 : 5'b00111;

  assign start   = (state == IDLE) && (state_next == COLLECT);
  assign capture = (state == COLLECT) && data_sample_en && in_win;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: open on the first index, abort on any gap or stray tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_sample_en && !cfg_err && (edge_cnt == first_idx))
          state_next = COLLECT;
      end
      COLLECT: begin
        if (!data_sample_en || !in_win)
          state_next = IDLE;
        else if (is_last)
          state_next = ((valid_after & need_mask) == need_mask) ? VOTE : IDLE;
      end
      VOTE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample slots, their valid bits and the per-window latched configuration.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slots     <= '0;
      valid     <= '0;
      first_reg <= '0;
      five_reg  <= 1'b0;
    end else if (start) begin
      slots[0]  <= rx_s;
      valid     <= 5'b00001;
      first_reg <= first_idx;
      five_reg  <= vote_mode;
    end else if (capture) begin
      slots[offset[2:0]] <= rx_s;
      valid              <= valid_after;
    end else if (state_next == IDLE) begin
      valid <= '0;
    end
  end

  // Output decode: count ones over the active slots and form the vote.
  always_comb begin
    used       = slots & need_mask;
    ones       = {2'b00, used[0]} + {2'b00, used[1]} + {2'b00, used[2]}
               + {2'b00, used[3]} + {2'b00, used[4]};
    vote_bit   = five_reg ? (ones >= 3'd3) : (ones >= 3'd2);
    vote_noise = (ones != 3'd0) && (ones != (five_reg ? 3'd5 : 3'd3));
    vote_now   = (state == VOTE);
  end

  // Registered results: strobe for one cycle, hold the bit between votes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      noise_err    <= 1'b0;
    end else begin
      sample_valid <= vote_now;
      noise_err    <= vote_now && vote_noise;
      if (vote_now) sampled_bit <= vote_bit;
    end
  end

endmodule

// File: doc/data_sampler_mv.md
DATA_SAMPLER_MV -- requirements
Module: data_sampler_mv

Interface
REQ-001 The block SHALL have parameter PRESCALE_WIDTH, default 6, giving the width of prescale and edge_cnt.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, legal 0..3, giving the number of RX_IN synchroniser flops.
REQ-003 Port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous and active-high.
REQ-005 Port data_sample_en  input  1  the sampling window is allowed while high.
REQ-006 Port RX_IN  input  1  raw serial line, idle high.
REQ-007 Port edge_cnt  input  PRESCALE_WIDTH  oversampling tick index within the current bit, 0..prescale-1.
REQ-008 Port prescale  input  PRESCALE_WIDTH  oversampling ratio per bit.
REQ-009 Port vote_mode  input  1  0 selects 3-sample majority, 1 selects 5-sample majority.
REQ-010 Port sampled_bit  output  1  registered majority result, held until the next vote.
REQ-011 Port sample_valid  output  1  one-cycle strobe marking a new sampled_bit.
REQ-012 Port noise_err  output  1  set with sample_valid when the captured samples were not unanimous.
REQ-013 Port cfg_err  output  1  high while the current prescale/vote_mode combination is illegal.

Function
REQ-014 RX_IN SHALL pass through SYNC_STAGES flops, each reset to 1; all capture uses the synchronised value (rx_s); with SYNC_STAGES=0, rx_s is RX_IN.
REQ-015 Window: C = prescale>>1 (floor); N = 3 (vote_mode=0) or 5 (vote_mode=1); sample indices C-(N-1)/2 .. C+(N-1)/2 inclusive.
REQ-016 Legality: prescale>=4 for N=3, prescale>=8 for N=5; otherwise cfg_err=1 (combinational from the inputs), no capture occurs, and the FSM stays in IDLE.
REQ-017 The FSM SHALL have states IDLE, COLLECT and VOTE.
REQ-018 IDLE->COLLECT on a cycle with data_sample_en=1, cfg_err=0 and edge_cnt equal to the first index: store rx_s in slot 0; clear all other slot-valid bits; latch N and C for the window.
REQ-019 In COLLECT, on a cycle with data_sample_en=1 and edge_cnt equal to first+k (k in 1..N-1): store rx_s in slot k and set its valid bit; a repeated index overwrites its slot.
REQ-020 COLLECT->VOTE on the capture cycle of the last index when all N slot-valid bits are then set.
REQ-021 COLLECT->IDLE, discarding all slots and emitting no strobe, on any of: data_sample_en=0; edge_cnt outside the window; last index reached with a slot missing.
REQ-022 VOTE (one cycle) SHALL register sampled_bit = 1 if ones > N/2; sample_valid=1; noise_err = 1 unless all N samples are equal; then go to IDLE. VOTE completes even if data_sample_en drops during it.
REQ-023 Latency: sample_valid SHALL rise exactly 1 CLK after the last-index capture edge, and 1+SYNC_STAGES CLKs after the RX_IN value that was sampled at that edge.
REQ-024 vote_mode and prescale changes SHALL be ignored mid-window (values latched at REQ-018) and take effect from the next window.
REQ-025 sample_valid and noise_err SHALL be low in every cycle that is not the cycle after VOTE; sampled_bit SHALL hold its value between votes.
REQ-026 The vote counter SHALL be 3 bits wide; slot storage SHALL be 5 bits, using only slots 0..N-1 when N=3.

Reset
REQ-027 While RST=1: FSM=IDLE; slots and valid bits cleared; sync flops=1; sampled_bit=1; sample_valid=0; noise_err=0.
REQ-028 RST asserted mid-window SHALL abort the window with no strobe; after release, the first vote requires a full new window.

Verification
REQ-029 prescale=16, vote_mode=0, rx_s=0 at edge_cnt 7..9 -> sample_valid pulses once at the cycle after edge_cnt=9; sampled_bit=0; noise_err=0.
REQ-030 prescale=16, vote_mode=1, samples 1,0,1,1,0 at edge_cnt 6..10 -> sampled_bit=1; noise_err=1; single-cycle strobe.
REQ-031 prescale=8, vote_mode=1 (indices 2..6), data_sample_en dropped at edge_cnt=4 -> no strobe; sampled_bit retains its previous value.
REQ-032 prescale=6, vote_mode=1 -> cfg_err=1 and no strobe over 3 bit periods; switching to vote_mode=0 -> cfg_err=0, votes resume at indices 2..4.
REQ-033 SYNC_STAGES=2: RX_IN step 1->0 three cycles before the window -> the vote reflects 0 and the strobe occurs 3 CLKs after the last-index RX_IN value.
REQ-034 RST pulse between the 2nd and 3rd captures -> no strobe; outputs at reset values; the next full window votes correctly.
